// File: rtl/alu_result_bcd.sv
// Sequential binary-to-BCD converter for the ALU result word: iterative double-dabble, one bit per clock.
// Optional ALU_BCD_SEG_EN adds a registered active-low 7-segment output (seg_n) alongside bcd.
module alu_result_bcd #(
  parameter int Width  = 4,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*Width-1:0]    in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
`ifdef ALU_BCD_SEG_EN
  output logic [7*DIGITS-1:0]   seg_n,
`endif
  output logic                  ovf
);

  // Handshake: a word is taken on a rising edge where in_valid && in_ready;
  // in_ready is low only while a conversion is running, and nothing is queued.

  localparam int NB = 2 * Width;
  localparam int CW = $clog2(NB + 1);
  localparam int DW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [NB-1:0]   shift_q;
  logic [DW-1:0]   dig_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_acc_q;

  logic            accept;
  logic            last_iter;
  logic [DW-1:0]   dig_adj;
  logic [DW-1:0]   dig_nxt;
  logic [NB-1:0]   shift_nxt;
  logic            carry_out;

  assign accept    = in_valid && in_ready;
  assign last_iter = (state == CONVERT) && (cnt_q == CW'(NB - 1));

  // One double-dabble step: correct every digit >= 5, then shift the whole chain left.
  always_comb begin
    dig_adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
    {carry_out, dig_nxt, shift_nxt} = {dig_adj, shift_q, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CONVERT;
      CONVERT: if (last_iter) state_nxt = DONE;
      DONE:    if (accept)    state_nxt = CONVERT;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != CONVERT);
  end

`ifdef ALU_BCD_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [7*DIGITS-1:0] seg_nxt;

  always_comb begin
    seg_nxt = '1;
    for (int i = 0; i < DIGITS; i++) begin
      seg_nxt[7*i +: 7] = seg7(dig_nxt[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= '1;
    end else if (last_iter) begin
      seg_n <= seg_nxt;
    end
  end
`endif

  // bcd/ovf are only written at completion, so an accept in DONE leaves the old digits shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      shift_q   <= in_data;
      dig_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      out_valid <= 1'b0;
    end else if (state == CONVERT) begin
      shift_q   <= shift_nxt;
      dig_q     <= dig_nxt;
      cnt_q     <= cnt_q + CW'(1);
      ovf_acc_q <= ovf_acc_q | carry_out;
      if (last_iter) begin
        bcd       <= dig_nxt;
        ovf       <= ovf_acc_q | carry_out;
        out_valid <= 1'b1;
      end
    end
  end

endmodule
